mcpu_loader: RTL
================

Name: mcpu_loader

Overview:
- Boot/program-load controller for the minimal 8-bit accumulator CPU and its 64x8 program/data SRAM.
- Holds the CPU in reset and streams a program image from a byte source (UART/host FIFO) into SRAM over a valid/ready handshake.
- Then releases the CPU and hands the memory bus to it.
- Owns the bus mux between itself and the CPU. Can re-load on request at any time.

Parameters:
- ADDR_W, 6, SRAM/CPU address width.
- DATA_W, 8, data width.
- LOAD_LEN, 64, bytes written per load. Legal range 1..2**ADDR_W. Address wraps never occur within a load.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-low
- start  in  1  level-sampled pulse. Begins a load from any state.
- in_data  in  DATA_W  image byte
- in_valid  in  1  in_data valid
- in_ready  out  1  loader accepts in_data this cycle
- cpu_rst  out  1  CPU reset, active-low, registered
- cpu_adr  in  ADDR_W  CPU address
- cpu_wdata  in  DATA_W  CPU write data
- cpu_rdata  out  DATA_W  read data to CPU
- cpu_oe  in  1  CPU read strobe, active-low
- cpu_we  in  1  CPU write strobe, active-low
- mem_adr  out  ADDR_W  SRAM address
- mem_wdata  out  DATA_W  SRAM write data
- mem_rdata  in  DATA_W  SRAM read data
- mem_oe  out  1  SRAM output enable, active-low
- mem_we  out  1  SRAM write enable, active-low
- busy  out  1  high in LOAD/WRITE/RELEASE
- done  out  1  high in RUN

Behaviour:
- Reset (rst=0 at posedge clk):
  - state=IDLE, cpu_rst=0, in_ready=0, busy=0, done=0.
  - Loader mem_oe=1, mem_we=1, load address=0, byte count=0.
  - rst overrides start.
- States: IDLE, LOAD, WRITE, RELEASE, RUN.
- IDLE:
  - CPU held (cpu_rst=0), memory strobes deasserted, cpu_rdata=0.
  - start=1 -> LOAD with address=0, count=0.
- LOAD:
  - in_ready=1.
  - in_valid=1 at posedge -> latch in_data into mem_wdata and current address into mem_adr, then -> WRITE.
  - in_valid=0 -> stay in LOAD. There is no timeout.
- WRITE:
  - Exactly one cycle with mem_we=0, mem_oe=1, in_ready=0. mem_adr/mem_wdata are stable the whole cycle.
  - At exit: address+1, count+1.
  - If count+1==LOAD_LEN -> RELEASE; else -> LOAD.
  - Sustained throughput: one byte per 2 cycles.
- RELEASE:
  - One cycle with cpu_rst=0 and strobes deasserted, so the CPU sees at least one clean reset edge after the last write.
  - -> RUN, with cpu_rst=1 registered at that edge.
- RUN:
  - done=1, cpu_rst=1.
  - Bus is combinational pass-through: mem_adr=cpu_adr, mem_wdata=cpu_wdata, mem_oe=cpu_oe, mem_we=cpu_we, cpu_rdata=mem_rdata.
  - The CPU strobes are qualified by clk-high inside the CPU, so no extra registering is permitted in this path.
- Outside RUN, the CPU strobes are ignored and cpu_rdata=0.
- start in LOAD/WRITE/RELEASE/RUN:
  - Restarts the load: -> LOAD with address=0, count=0, cpu_rst=0 at the same edge.
  - In WRITE, the pending write completes in that cycle before restart (mem_we low remains for that cycle). In_ready for the restart starts next cycle.
- Handshake: a byte is consumed only on cycles where in_valid&&in_ready at posedge. in_data may change freely when in_ready=0.
- Load address counter is ADDR_W+1 bits wide for the count compare. LOAD_LEN=2**ADDR_W finishes at address 2**ADDR_W-1 and never drives wrapped address 0.
- The loader never asserts mem_oe low (no verify read).

Test Plan:
- Reset/idle: rst=0 for 3 cycles with start=1 -> state IDLE, cpu_rst=0, mem_we=1, mem_oe=1, in_ready=0, busy=0, done=0.
- Full load, LOAD_LEN=64: start, then stream bytes 0x00..0x3F with in_valid always 1 -> 64 mem_we low pulses at mem_adr 0..63 with mem_wdata==mem_adr, in_ready duty 50%, RELEASE one cycle, then cpu_rst=1, done=1 at cycle 129 after start.
- Backpressure/gaps: in_valid toggled randomly, LOAD_LEN=4, bytes A5,5A,FF,00 -> exactly 4 writes at addr 0..3 in order, no duplicate or dropped byte.
- RUN pass-through: after load, CPU drives adr=0x2A, oe=0, then we=0 with wdata=0x3C -> mem pins mirror the CPU combinationally; cpu_rdata follows mem_rdata=0x81.
- Restart: assert start in RUN, then again mid-load after 10 bytes -> cpu_rst=0 same edge, address restarts at 0, in-flight WRITE completes, done=0, busy=1.
- Reset mid-load: rst=0 during WRITE of byte 7 -> next edge state IDLE, mem_we=1, count=0; a following start reloads from address 0.

Source files
------------

// File: rtl/mcpu_loader.sv
// Boot loader for the 8-bit accumulator CPU: streams a program image into SRAM
// while holding the CPU in reset, then releases the CPU and hands it the bus.
module mcpu_loader #(
   parameter int ADDR_W   = 6,
   parameter int DATA_W   = 8,
   parameter int LOAD_LEN = 64
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_valid,
   output logic              in_ready,
   output logic              cpu_rst,
   input  logic [ADDR_W-1:0] cpu_adr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic [DATA_W-1:0] cpu_rdata,
   input  logic              cpu_oe,
   input  logic              cpu_we,
   output logic [ADDR_W-1:0] mem_adr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              mem_oe,
   output logic              mem_we,
   output logic              busy,
   output logic              done
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_WRITE,
      S_RELEASE,
      S_RUN
   } state_t;

   // Count is one bit wider than the address so LOAD_LEN == 2**ADDR_W is reachable.
   localparam logic [ADDR_W:0] LEN = (ADDR_W+1)'(LOAD_LEN);
   localparam logic [ADDR_W:0] ONE = (ADDR_W+1)'(1);

   state_t            state_q, state_d;
   logic [ADDR_W:0]   cnt_q, cnt_d;
   logic [ADDR_W:0]   cnt_inc;
   logic [ADDR_W-1:0] wadr_q, wadr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic              cpu_rst_q, cpu_rst_d;

   assign cnt_inc = cnt_q + ONE;

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      wadr_d    = wadr_q;
      wdata_d   = wdata_q;
      cpu_rst_d = cpu_rst_q;
      case (state_q)
         S_IDLE: begin
            cpu_rst_d = 1'b0;
         end
         S_LOAD: begin
            if (in_valid) begin
               wadr_d  = cnt_q[ADDR_W-1:0];
               wdata_d = in_data;
               state_d = S_WRITE;
            end
         end
         S_WRITE: begin
            cnt_d   = cnt_inc;
            state_d = (cnt_inc == LEN) ? S_RELEASE : S_LOAD;
         end
         S_RELEASE: begin
            cpu_rst_d = 1'b1;
            state_d   = S_RUN;
         end
         S_RUN: begin
            cpu_rst_d = 1'b1;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
      // A restart wins over every transition; an in-flight WRITE still drives mem_we this cycle.
      if (start) begin
         state_d   = S_LOAD;
         cnt_d     = '0;
         cpu_rst_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         wadr_q    <= '0;
         wdata_q   <= '0;
         cpu_rst_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         wadr_q    <= wadr_d;
         wdata_q   <= wdata_d;
         cpu_rst_q <= cpu_rst_d;
      end
   end

   // The CPU qualifies its strobes with clk internally, so RUN is a pure combinational mux.
   always_comb begin
      in_ready  = (state_q == S_LOAD);
      busy      = (state_q == S_LOAD) || (state_q == S_WRITE) || (state_q == S_RELEASE);
      done      = (state_q == S_RUN);
      cpu_rst   = cpu_rst_q;
      mem_adr   = wadr_q;
      mem_wdata = wdata_q;
      mem_oe    = 1'b1;
      mem_we    = 1'b1;
      cpu_rdata = '0;
      if (state_q == S_WRITE) begin
         mem_we = 1'b0;
      end
      if (state_q == S_RUN) begin
         mem_adr   = cpu_adr;
         mem_wdata = cpu_wdata;
         mem_oe    = cpu_oe;
         mem_we    = cpu_we;
         cpu_rdata = mem_rdata;
      end
   end

endmodule
